// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch-flush bubbles.
// Two saturating counters record the number of stall edges and the number of flush edges.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic [1:0]        id_aluop,
  input  logic              ex_flush,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              hazard,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic [1:0]        ex_aluop,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic rs2_used;
  logic rd_match;
  logic load_use;
  logic bubble;

  // Only R-type, branch and store instructions actually read rs2.
  assign rs2_used = !id_alusrc || id_memwrite;
  assign rd_match = (ex_rd == id_rs1) || (rs2_used && (ex_rd == id_rs2));
  assign load_use = reset && id_valid && ex_valid && ex_memread &&
                    (ex_rd != 5'd0) && rd_match;

  // A taken branch kills the dependent instruction, so the stall is pointless.
  assign hazard     = load_use && !ex_flush;
  assign pc_write   = !hazard;
  assign ifid_write = !hazard;
  assign bubble     = ex_flush || hazard;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_aluop    <= 2'b00;
    end else if (bubble || !id_valid) begin
      ex_valid    <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_aluop    <= 2'b00;
    end else begin
      ex_valid    <= 1'b1;
      ex_alusrc   <= id_alusrc;
      ex_memtoreg <= id_memtoreg;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_branch   <= id_branch;
      ex_aluop    <= id_aluop;
    end
  end

  // Data fields are don't-care inside a bubble; they simply hold during a stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_pc     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs1    <= 5'd0;
      ex_rs2    <= 5'd0;
      ex_rd     <= 5'd0;
      ex_funct3 <= 3'd0;
      ex_funct7 <= 7'd0;
    end else if (!hazard) begin
      ex_pc     <= id_pc;
      ex_rd1    <= id_rd1;
      ex_rd2    <= id_rd2;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_funct3 <= id_funct3;
      ex_funct7 <= id_funct7;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a behavioural model of the pipeline slot is compared every cycle
// under directed and random stimulus; a narrow counter build exercises saturation.
module tb_id_ex_stage;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic id_valid;
  logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic [6:0] id_funct7;
  logic id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
  logic [1:0] id_aluop;
  logic ex_flush;
  logic pc_write, ifid_write, hazard, ex_valid;
  logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [6:0] ex_funct7;
  logic ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [1:0] ex_aluop;
  logic [CW-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_alusrc(id_alusrc),
    .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_branch(id_branch), .id_aluop(id_aluop),
    .ex_flush(ex_flush), .pc_write(pc_write), .ifid_write(ifid_write), .hazard(hazard),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_aluop(ex_aluop), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of what EX holds: valid flag, control bits, data snapshot, counters.
  logic         m_valid = 1'b0;
  logic [7:0]   m_ctrl  = 8'd0;
  logic [152:0] m_data  = '0;
  logic [4:0]   m_rd    = 5'd0;
  logic         m_known = 1'b0;
  int           m_stall = 0;
  int           m_flush = 0;
  logic         m_h;

  function automatic logic [7:0] id_ctrl();
    return {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop};
  endfunction
  function automatic logic [7:0] ex_ctrl();
    return {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop};
  endfunction
  function automatic logic [152:0] id_data();
    return {id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7};
  endfunction
  function automatic logic [152:0] ex_data();
    return {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7};
  endfunction

  // EX holds a load (bit 4 of ctrl is memread) whose destination feeds an operand ID reads.
  function automatic logic model_hazard();
    logic uses_rs2, dep;
    uses_rs2 = !id_alusrc || id_memwrite;
    dep = (m_rd == id_rs1) || (uses_rs2 && (m_rd == id_rs2));
    return reset && id_valid && m_valid && m_ctrl[4] && (m_rd != 5'd0) && dep && !ex_flush;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic comb_check();
    #1;
    m_h = model_hazard();
    chk("hazard", 160'(hazard), 160'(m_h));
    chk("pc_write", 160'(pc_write), 160'(!m_h));
    chk("ifid_write", 160'(ifid_write), 160'(!m_h));
  endtask

  task automatic edge_check();
    @(posedge clk);
    if (!reset) begin
      m_valid = 1'b0; m_ctrl = 8'd0; m_data = '0; m_rd = 5'd0; m_known = 1'b1;
      m_stall = 0; m_flush = 0;
    end else begin
      if (ex_flush || m_h) begin
        m_valid = 1'b0; m_ctrl = 8'd0; m_known = 1'b0;
      end else begin
        m_valid = id_valid;
        m_ctrl  = id_valid ? id_ctrl() : 8'd0;
        m_data  = id_data();
        m_rd    = id_rd;
        m_known = 1'b1;
      end
      if (m_h && m_stall < CMAX) m_stall++;
      if (ex_flush && m_flush < CMAX) m_flush++;
    end
    #1;
    chk("ex_valid", 160'(ex_valid), 160'(m_valid));
    chk("ex_ctrl", 160'(ex_ctrl()), 160'(m_ctrl));
    if (m_known) chk("ex_data", 160'(ex_data()), 160'(m_data));
    chk("stall_cnt", 160'(stall_cnt), 160'(m_stall));
    chk("flush_cnt", 160'(flush_cnt), 160'(m_flush));
  endtask

  task automatic cycle();
    comb_check();
    edge_check();
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic alusrc, input logic memread,
                           input logic memwrite, input logic regwrite);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_alusrc = alusrc; id_memread = memread; id_memwrite = memwrite;
    id_regwrite = regwrite; id_memtoreg = memread; id_branch = 1'b0; id_aluop = 2'b00;
    id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
  endtask

  task automatic rand_inputs();
    set_instr($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 1) == 1,
              1'($urandom), 1'($urandom));
    id_memtoreg = 1'($urandom); id_branch = 1'($urandom); id_aluop = 2'($urandom);
    ex_flush = $urandom_range(0, 99) < 15;
    reset = $urandom_range(0, 99) >= 2;
  endtask

  initial begin
    reset = 1'b0; ex_flush = 1'b0;
    set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    comb_check();
    chk("lit_rst_pc_write", 160'(pc_write), 160'(1));
    edge_check();
    edge_check();
    chk("lit_rst_ex_valid", 160'(ex_valid), 160'(0));
    chk("lit_rst_ex_data", 160'(ex_data()), 160'(0));
    reset = 1'b1;

    // lw x5 followed by a dependent add
    set_instr(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    set_instr(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    comb_check();
    chk("lit_lu_hazard", 160'(hazard), 160'(1));
    chk("lit_lu_pc_write", 160'(pc_write), 160'(0));
    edge_check();
    chk("lit_lu_bubble_valid", 160'(ex_valid), 160'(0));
    chk("lit_lu_bubble_regwrite", 160'(ex_regwrite), 160'(0));
    chk("lit_lu_stall_cnt", 160'(stall_cnt), 160'(1));
    comb_check();
    chk("lit_lu_release", 160'(hazard), 160'(0));
    edge_check();
    chk("lit_add_valid", 160'(ex_valid), 160'(1));
    chk("lit_add_rs1", 160'(ex_rs1), 160'(5));

    // load to x0 never stalls; addi does not read rs2
    set_instr(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    set_instr(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    comb_check();
    chk("lit_x0_hazard", 160'(hazard), 160'(0));
    edge_check();
    set_instr(1'b1, 5'd1, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    comb_check();
    chk("lit_addi_hazard", 160'(hazard), 160'(0));
    edge_check();

    // store data dependence, then same cycle as a flush
    set_instr(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    set_instr(1'b1, 5'd1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    comb_check();
    chk("lit_sw_hazard", 160'(hazard), 160'(1));
    ex_flush = 1'b1;
    comb_check();
    chk("lit_flush_hazard", 160'(hazard), 160'(0));
    chk("lit_flush_pc_write", 160'(pc_write), 160'(1));
    edge_check();
    chk("lit_flush_valid", 160'(ex_valid), 160'(0));
    chk("lit_flush_cnt", 160'(flush_cnt), 160'(1));
    chk("lit_flush_stall_cnt", 160'(stall_cnt), 160'(1));
    ex_flush = 1'b0;

    // self-dependent loads stall every other cycle until the counter saturates
    set_instr(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) cycle();
    chk("lit_stall_sat", 160'(stall_cnt), 160'(CMAX));
    for (int i = 0; i < 4; i++) cycle();
    chk("lit_stall_sat_hold", 160'(stall_cnt), 160'(CMAX));

    // reset in the middle of a stall
    for (int i = 0; i < 4 && !model_hazard(); i++) cycle();
    comb_check();
    chk("lit_pre_rst_hazard", 160'(hazard), 160'(1));
    reset = 1'b0;
    comb_check();
    chk("lit_rst_stall_hazard", 160'(hazard), 160'(0));
    chk("lit_rst_stall_pc_write", 160'(pc_write), 160'(1));
    edge_check();
    chk("lit_rst_stall_valid", 160'(ex_valid), 160'(0));
    chk("lit_rst_stall_data", 160'(ex_data()), 160'(0));
    chk("lit_rst_stall_cnt", 160'({stall_cnt, flush_cnt}), 160'(0));
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
